// File: rtl/decifra_simon.sv
`default_nettype none
// ============================================================================
//  Module   : decifra_simon
//  Brief    : Iterative Simon128/128 decryption core, one round per clock.
//             Round keys are regenerated on the fly: the forward schedule is
//             run up to k66/k67, then walked backwards alongside the rounds,
//             so no key storage is needed.
//  Revision : 1.0 - initial release
// ============================================================================
module decifra_simon #(
    parameter int          W       = 64,
    parameter int          T       = 68,
    parameter logic [63:0] C_CONST = 64'hFFFF_FFFF_FFFF_FFFC,
    parameter logic [61:0] Z_SEQ   = 62'b1010111101_1100000011_0100100110_0010100001_0001111110_0101101100_11
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           start_i,
    input  logic [2*W-1:0] ct_i,
    input  logic [2*W-1:0] k0_i,
    output logic [2*W-1:0] pt_o,
    output logic           busy_o,
    output logic           done_o
);

    // Counter values marking the end of each phase.
    localparam logic [6:0] CNT_FWD_LAST = 7'(T - 3);  // last forward step (i = 65)
    localparam logic [6:0] CNT_DEC_FIRST = 7'(T - 1); // first decryption round (r = 67)

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_KFWD = 2'd1,
        S_DEC  = 2'd2
    } state_t;

    state_t         state_q;
    logic [W-1:0]   x_q;
    logic [W-1:0]   y_q;
    logic [W-1:0]   ka_q;
    logic [W-1:0]   kb_q;
    logic [6:0]     cnt_q;
    logic [2*W-1:0] pt_q;
    logic           busy_q;
    logic           done_q;

    // Next-value terms of the datapath.
    logic [6:0]     zidx_d;
    logic [5:0]     zmod_d;
    logic           zbit_d;
    logic [W-1:0]   kb_fwd_d;
    logic [W-1:0]   ka_inv_d;
    logic [W-1:0]   fy_d;
    logic [W-1:0]   y_dec_d;

    // Rotate helpers: fixed shifts, pure wiring.
    function automatic logic [W-1:0] rol(input logic [W-1:0] v, input int n);
        return (v << n) | (v >> (W - n));
    endfunction

    function automatic logic [W-1:0] ror(input logic [W-1:0] v, input int n);
        return (v >> n) | (v << (W - n));
    endfunction

    // z-sequence index: forward steps use i, inverse steps use r-2. For r<2
    // the inverse key is never consumed, so the index is simply parked at 0.
    always_comb begin
        zidx_d = cnt_q;
        if (state_q == S_DEC) begin
            zidx_d = (cnt_q < 7'd2) ? 7'd0 : (cnt_q - 7'd2);
        end
        zmod_d = (zidx_d >= 7'd62) ? 6'(zidx_d - 7'd62) : zidx_d[5:0];
        zbit_d = Z_SEQ[6'd61 - zmod_d];
    end

    // Forward/inverse key schedule and the inverse round function.
    always_comb begin
        kb_fwd_d = ka_q ^ C_CONST ^ {{(W-1){1'b0}}, zbit_d} ^ ror(kb_q, 3) ^ ror(kb_q, 4);
        ka_inv_d = kb_q ^ C_CONST ^ {{(W-1){1'b0}}, zbit_d} ^ ror(ka_q, 3) ^ ror(ka_q, 4);
        fy_d     = (rol(y_q, 1) & rol(y_q, 8)) ^ rol(y_q, 2);
        y_dec_d  = x_q ^ fy_d ^ kb_q;
    end

    // Control FSM with registered datapath and outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            x_q     <= '0;
            y_q     <= '0;
            ka_q    <= '0;
            kb_q    <= '0;
            cnt_q   <= '0;
            pt_q    <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (start_i) begin
                        x_q     <= ct_i[2*W-1:W];
                        y_q     <= ct_i[W-1:0];
                        ka_q    <= k0_i[W-1:0];
                        kb_q    <= k0_i[2*W-1:W];
                        cnt_q   <= '0;
                        busy_q  <= 1'b1;
                        state_q <= S_KFWD;
                    end
                end
                S_KFWD: begin
                    kb_q <= kb_fwd_d;
                    ka_q <= kb_q;
                    if (cnt_q == CNT_FWD_LAST) begin
                        cnt_q   <= CNT_DEC_FIRST;
                        state_q <= S_DEC;
                    end else begin
                        cnt_q <= cnt_q + 7'd1;
                    end
                end
                S_DEC: begin
                    x_q  <= y_q;
                    y_q  <= y_dec_d;
                    kb_q <= ka_q;
                    ka_q <= ka_inv_d;
                    if (cnt_q == 7'd0) begin
                        pt_q    <= {y_q, y_dec_d};
                        done_q  <= 1'b1;
                        busy_q  <= 1'b0;
                        state_q <= S_IDLE;
                    end else begin
                        cnt_q <= cnt_q - 7'd1;
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign pt_o   = pt_q;
    assign busy_o = busy_q;
    assign done_o = done_q;

endmodule
`default_nettype wire

// File: tb/tb_decifra_simon.sv
`default_nettype none
// ============================================================================
//  Module   : tb_decifra_simon
//  Brief    : Self-checking bench for decifra_simon with an expected-result
//             queue and a standalone Simon128/128 reference model.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_decifra_simon;

    localparam int LAT = 134;

    logic         clk;
    logic         rst_n;
    logic         start_i;
    logic [127:0] ct_i;
    logic [127:0] k0_i;
    logic [127:0] pt_o;
    logic         busy_o;
    logic         done_o;

    int total = 0;
    int bad   = 0;

    logic [127:0] sb [$];
    logic [63:0]  rk [0:67];
    logic [61:0]  zs = 62'b10101111011100000011010010011000101000010001111110010110110011;

    decifra_simon dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .start_i (start_i),
        .ct_i    (ct_i),
        .k0_i    (k0_i),
        .pt_o    (pt_o),
        .busy_o  (busy_o),
        .done_o  (done_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Absolute time bound in case a wait loop is broken.
    initial begin
        #3ms;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] rotl(input logic [63:0] v, input int n);
        return (v << n) | (v >> (64 - n));
    endfunction

    function automatic logic [63:0] rotr(input logic [63:0] v, input int n);
        return (v >> n) | (v << (64 - n));
    endfunction

    // Reference key expansion in the published form (~k ^ 3 ^ z ^ tmp).
    task automatic expand(input logic [127:0] key);
        logic [63:0] tmp;
        rk[0] = key[63:0];
        rk[1] = key[127:64];
        for (int i = 0; i < 66; i++) begin
            tmp = rotr(rk[i+1], 3);
            tmp = tmp ^ rotr(tmp, 1);
            rk[i+2] = ~rk[i] ^ tmp ^ {63'd0, zs[61 - (i % 62)]} ^ 64'd3;
        end
    endtask

    function automatic logic [127:0] encrypt(input logic [127:0] pt);
        logic [63:0] x, y, t;
        x = pt[127:64];
        y = pt[63:0];
        for (int i = 0; i < 68; i++) begin
            t = x;
            x = y ^ (rotl(x, 1) & rotl(x, 8)) ^ rotl(x, 2) ^ rk[i];
            y = t;
        end
        return {x, y};
    endfunction

    function automatic logic [127:0] decrypt(input logic [127:0] ct);
        logic [63:0] x, y, t;
        x = ct[127:64];
        y = ct[63:0];
        for (int i = 67; i >= 0; i--) begin
            t = y;
            y = x ^ (rotl(y, 1) & rotl(y, 8)) ^ rotl(y, 2) ^ rk[i];
            x = t;
        end
        return {x, y};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [127:0] rnd128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    // Drive one accepted start (edge E0) and push the expected plaintext.
    task automatic start_op(input logic [127:0] ct, input logic [127:0] key, input logic [127:0] exp);
        start_i = 1'b1;
        ct_i    = ct;
        k0_i    = key;
        sb.push_back(exp);
        tick();
        start_i = 1'b0;
        ct_i    = rnd128();
        k0_i    = rnd128();
    endtask

    // Wait for done_o; check latency, busy width and the popped expectation.
    // A start pulse with a different ciphertext is injected at inject_at.
    task automatic wait_done(input int inject_at);
        int lat;
        int busy_cnt;
        bit seen;
        logic [127:0] exp;
        lat      = 0;
        seen     = 1'b0;
        busy_cnt = busy_o ? 1 : 0;
        while (lat < 300 && !seen) begin
            start_i = 1'b0;
            if (lat == inject_at) begin
                start_i = 1'b1;
                ct_i    = rnd128();
            end
            tick();
            lat++;
            if (done_o) begin
                seen = 1'b1;
            end else if (busy_o) begin
                busy_cnt++;
            end
        end
        start_i = 1'b0;
        chk("done_seen", {127'd0, seen}, 128'd1);
        chk("latency", 128'(lat), 128'(LAT));
        chk("busy_width", 128'(busy_cnt), 128'(LAT));
        chk("busy_at_done", {127'd0, busy_o}, 128'd0);
        if (seen) begin
            if (sb.size() == 0) begin
                chk("sb_nonempty", 128'd0, 128'd1);
            end else begin
                exp = sb.pop_front();
                chk("pt", pt_o, exp);
            end
        end
    endtask

    localparam logic [127:0] KAT_CT  = 128'h49681b1e1e54fe3f_65aa832af84e0bbc;
    localparam logic [127:0] KAT_KEY = 128'h0f0e0d0c0b0a0908_0706050403020100;
    localparam logic [127:0] KAT_PT  = 128'h6373656420737265_6c6c657661727420;

    initial begin
        logic [127:0] pt, key, ct, exp0;
        rst_n   = 1'b0;
        start_i = 1'b0;
        ct_i    = '0;
        k0_i    = '0;
        #12;
        chk("rst_pt", pt_o, 128'd0);
        chk("rst_busy", {127'd0, busy_o}, 128'd0);
        chk("rst_done", {127'd0, done_o}, 128'd0);
        tick();
        rst_n = 1'b1;
        tick();
        chk("idle_busy", {127'd0, busy_o}, 128'd0);

        // Known-answer vector, then pulse width and output hold.
        start_op(KAT_CT, KAT_KEY, KAT_PT);
        wait_done(-1);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("done_pulse", {127'd0, done_o}, 128'd0);
            chk("pt_hold", pt_o, KAT_PT);
        end

        // Start while busy is ignored.
        start_op(KAT_CT, KAT_KEY, KAT_PT);
        wait_done(50);

        // Back-to-back: new start in the done_o cycle with zero key/ct.
        start_op(KAT_CT, KAT_KEY, KAT_PT);
        wait_done(-1);
        expand(128'd0);
        exp0 = decrypt(128'd0);
        start_op(128'd0, 128'd0, exp0);
        chk("b2b_busy", {127'd0, busy_o}, 128'd1);
        chk("b2b_pt_kept", pt_o, KAT_PT);
        wait_done(-1);

        // Reset mid-operation aborts without done_o.
        start_op(KAT_CT, KAT_KEY, KAT_PT);
        for (int i = 0; i < 80; i++) begin
            tick();
            if (done_o) chk("early_done", 128'd1, 128'd0);
        end
        rst_n = 1'b0;
        #1;
        chk("abort_pt", pt_o, 128'd0);
        chk("abort_busy", {127'd0, busy_o}, 128'd0);
        chk("abort_done", {127'd0, done_o}, 128'd0);
        void'(sb.pop_back());
        tick();
        rst_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            if (done_o || busy_o) chk("post_abort_idle", 128'd1, 128'd0);
        end
        start_op(KAT_CT, KAT_KEY, KAT_PT);
        wait_done(-1);

        // Random round trips against the reference encryption.
        for (int n = 0; n < 200; n++) begin
            pt  = rnd128();
            key = rnd128();
            expand(key);
            ct = encrypt(pt);
            start_op(ct, key, pt);
            wait_done(-1);
        end

        chk("sb_drained", 128'(sb.size()), 128'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
